// File: rtl/bp_me_nonsynth_tr_sequencer.sv
// Trace-replay sequencer: feeds trace packets to one LCE with bounded outstanding commands,
// detects completion and hangs. Optional cycle counter under BP_ME_NONSYNTH_TR_SEQ_PERF_EN.
module bp_me_nonsynth_tr_sequencer #(
  parameter int unsigned tr_pkt_width_p    = 128,
  parameter int unsigned max_outstanding_p = 4,
  parameter int unsigned timeout_cycles_p  = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [tr_pkt_width_p-1:0] tr_pkt_i,
  input  logic                      tr_pkt_v_i,
  input  logic                      tr_pkt_last_i,
  output logic                      tr_pkt_yumi_o,
  output logic [tr_pkt_width_p-1:0] lce_tr_pkt_o,
  output logic                      lce_tr_pkt_v_o,
  input  logic                      lce_tr_pkt_yumi_i,
  input  logic                      lce_tr_resp_v_i,
  output logic                      lce_tr_resp_ready_o,
  output logic [3:0]                outstanding_o,
  output logic [31:0]               sent_count_o,
  output logic [31:0]               recv_count_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [31:0]               total_cycles_o
);

  localparam int unsigned out_width_lp = 4;
  localparam int unsigned cnt_width_lp = 32;

  typedef enum logic [2:0] {
    e_idle,
    e_send,
    e_drain,
    e_done,
    e_error
  } state_e;

  state_e                    state_r, state_n;
  logic [out_width_lp-1:0]   outstanding_r, outstanding_n;
  logic [cnt_width_lp-1:0]   sent_r, sent_n;
  logic [cnt_width_lp-1:0]   recv_r, recv_n;
  logic [cnt_width_lp-1:0]   wd_r, wd_n;
  logic                      done_r, error_r;
  logic                      active, send, resp, spurious, resp_ok, timeout;

  // Next-state and handshake logic
  always_comb begin
    state_n             = state_r;
    lce_tr_pkt_o        = tr_pkt_i;
    lce_tr_pkt_v_o      = 1'b0;
    tr_pkt_yumi_o       = 1'b0;
    lce_tr_resp_ready_o = 1'b0;
    active              = 1'b0;
    send                = 1'b0;
    resp                = 1'b0;
    spurious            = 1'b0;
    resp_ok             = 1'b0;
    timeout             = 1'b0;
    outstanding_n       = outstanding_r;
    sent_n              = sent_r;
    recv_n              = recv_r;
    wd_n                = wd_r;

    if (state_r == e_send) begin
      lce_tr_pkt_v_o = tr_pkt_v_i & (outstanding_r < out_width_lp'(max_outstanding_p));
      tr_pkt_yumi_o  = lce_tr_pkt_v_o & lce_tr_pkt_yumi_i;
    end
    active              = (state_r == e_send) || (state_r == e_drain);
    lce_tr_resp_ready_o = active;

    send     = tr_pkt_yumi_o;
    resp     = lce_tr_resp_ready_o & lce_tr_resp_v_i;
    spurious = resp & (outstanding_r == '0);
    resp_ok  = resp & ~spurious;

    outstanding_n = outstanding_r + out_width_lp'(send) - out_width_lp'(resp_ok);
    sent_n        = sent_r + cnt_width_lp'(send);
    recv_n        = recv_r + cnt_width_lp'(resp_ok);

    // Watchdog only runs while something is in flight and no response arrives
    if ((outstanding_r == '0) || resp)
      wd_n = '0;
    else if (active)
      wd_n = wd_r + cnt_width_lp'(1);
    timeout = active && (outstanding_r != '0) && !resp
              && (wd_r == cnt_width_lp'(timeout_cycles_p - 1));

    case (state_r)
      e_idle:  if (start_i) state_n = e_send;
      e_send:  if (send && tr_pkt_last_i) state_n = e_drain;
      e_drain: if (outstanding_n == '0) state_n = e_done;
      default: state_n = state_r;
    endcase

    // Error outranks done when both land in the same cycle
    if (active && (spurious || timeout))
      state_n = e_error;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r       <= e_idle;
      outstanding_r <= '0;
      sent_r        <= '0;
      recv_r        <= '0;
      wd_r          <= '0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_n;
      outstanding_r <= outstanding_n;
      sent_r        <= sent_n;
      recv_r        <= recv_n;
      wd_r          <= wd_n;
      done_r        <= (state_n == e_done);
      error_r       <= (state_n == e_error);
    end
  end

  assign outstanding_o = outstanding_r;
  assign sent_count_o  = sent_r;
  assign recv_count_o  = recv_r;
  assign done_o        = done_r;
  assign error_o       = error_r;

`ifdef BP_ME_NONSYNTH_TR_SEQ_PERF_EN
  logic [cnt_width_lp-1:0] cycles_r;

  // Replay cycle counter; holds its value once done or error is reached
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycles_r <= '0;
    end else begin
      if ((state_r == e_idle) && start_i)
        cycles_r <= '0;
      else if (active)
        cycles_r <= cycles_r + cnt_width_lp'(1);
      if ((state_r != e_done) && (state_n == e_done))
        $display("tr_sequencer: LCE sent=%0d recv=%0d total_cycles=%0d",
                 sent_n, recv_n, cycles_r + cnt_width_lp'(1));
    end
  end

  assign total_cycles_o = cycles_r;
`else
  assign total_cycles_o = '0;
`endif

endmodule

// File: tb/tb_bp_me_nonsynth_tr_sequencer.sv
// Directed bench for bp_me_nonsynth_tr_sequencer with a scoreboard on packets issued to the LCE.
module tb_bp_me_nonsynth_tr_sequencer;

  localparam int unsigned W = 128;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [W-1:0]  tr_pkt_i = '0;
  logic          tr_pkt_v_i = 1'b0;
  logic          tr_pkt_last_i = 1'b0;
  logic          tr_pkt_yumi_o;
  logic [W-1:0]  lce_tr_pkt_o;
  logic          lce_tr_pkt_v_o;
  logic          lce_tr_pkt_yumi_i = 1'b1;
  logic          lce_tr_resp_v_i = 1'b0;
  logic          lce_tr_resp_ready_o;
  logic [3:0]    outstanding_o;
  logic [31:0]   sent_count_o, recv_count_o, total_cycles_o;
  logic          done_o, error_o;

  bp_me_nonsynth_tr_sequencer #(
    .tr_pkt_width_p(W), .max_outstanding_p(4), .timeout_cycles_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .tr_pkt_i(tr_pkt_i), .tr_pkt_v_i(tr_pkt_v_i), .tr_pkt_last_i(tr_pkt_last_i),
    .tr_pkt_yumi_o(tr_pkt_yumi_o),
    .lce_tr_pkt_o(lce_tr_pkt_o), .lce_tr_pkt_v_o(lce_tr_pkt_v_o),
    .lce_tr_pkt_yumi_i(lce_tr_pkt_yumi_i),
    .lce_tr_resp_v_i(lce_tr_resp_v_i), .lce_tr_resp_ready_o(lce_tr_resp_ready_o),
    .outstanding_o(outstanding_o), .sent_count_o(sent_count_o), .recv_count_o(recv_count_o),
    .done_o(done_o), .error_o(error_o), .total_cycles_o(total_cycles_o)
  );

  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_pass  = 0;
  int           pkt_seq = 0;
  int           pkt_left = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] mk_pkt(input int n);
    return {16'hC0DE, 16'(n), 64'hA5A5_5A5A_0F0F_F0F0, 32'(n * 7 + 1)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every packet the LCE accepts must match the next one offered
  always @(negedge clk) begin
    #2;
    if (!reset_i && lce_tr_pkt_v_o && lce_tr_pkt_yumi_i) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL lce_pkt: unexpected send %0h", lce_tr_pkt_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (lce_tr_pkt_o === e && tr_pkt_yumi_o === 1'b1) n_pass++;
        else $display("FAIL lce_pkt: got %0h yumi %0b expected %0h yumi 1",
                      lce_tr_pkt_o, tr_pkt_yumi_o, e);
      end
    end
  end

  task automatic present_next();
    if (pkt_left > 0) begin
      tr_pkt_i      = mk_pkt(pkt_seq);
      tr_pkt_last_i = (pkt_left == 1);
      tr_pkt_v_i    = 1'b1;
      exp_q.push_back(mk_pkt(pkt_seq));
      pkt_seq++;
      pkt_left--;
    end else begin
      tr_pkt_v_i    = 1'b0;
      tr_pkt_last_i = 1'b0;
    end
  endtask

  // One clock cycle starting and ending at a falling edge
  task automatic step(input logic resp);
    logic c;
    lce_tr_resp_v_i = resp;
    #1;
    c = tr_pkt_yumi_o;
    @(negedge clk);
    lce_tr_resp_v_i = 1'b0;
    if (c) present_next();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    start_i = 1'b0;
    tr_pkt_v_i = 1'b0;
    tr_pkt_last_i = 1'b0;
    lce_tr_resp_v_i = 1'b0;
    pkt_left = 0;
    exp_q.delete();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic do_start(input int n);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    pkt_left = n;
    present_next();
  endtask

  initial begin
    int n;
    // Reset values
    @(negedge clk);
    chk("rst_outstanding", 32'(outstanding_o), 0);
    chk("rst_sent", sent_count_o, 0);
    chk("rst_recv", recv_count_o, 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_error", 32'(error_o), 0);
    chk("rst_ready", 32'(lce_tr_resp_ready_o), 0);
    chk("rst_pkt_v", 32'(lce_tr_pkt_v_o), 0);
    reset_i = 1'b0;

    // Single packet, response five cycles after the send
    @(negedge clk);
    do_start(1);
    step(1'b0);
    chk("single_out_after_send", 32'(outstanding_o), 1);
    repeat (4) step(1'b0);
    chk("single_done_before_resp", 32'(done_o), 0);
    step(1'b1);
    chk("single_done", 32'(done_o), 1);
    chk("single_sent", sent_count_o, 1);
    chk("single_recv", recv_count_o, 1);
    chk("single_out", 32'(outstanding_o), 0);
    chk("single_ready_done", 32'(lce_tr_resp_ready_o), 0);
    chk("single_q_empty", 32'(exp_q.size()), 0);

    // Credit limit: ten packets, responses withheld
    do_reset();
    do_start(10);
    repeat (12) step(1'b0);
    chk("credit_sent", sent_count_o, 4);
    chk("credit_out", 32'(outstanding_o), 4);
    chk("credit_pkt_v_low", 32'(lce_tr_pkt_v_o), 0);
    step(1'b1);
    chk("credit_out_after_resp", 32'(outstanding_o), 3);
    chk("credit_recv", recv_count_o, 1);
    step(1'b0);
    chk("credit_one_more_sent", sent_count_o, 5);
    chk("credit_out_full_again", 32'(outstanding_o), 4);

    // Simultaneous send and response at outstanding=3
    step(1'b1);
    chk("sim_pre_out", 32'(outstanding_o), 3);
    step(1'b1);
    chk("sim_out", 32'(outstanding_o), 3);
    chk("sim_sent", sent_count_o, 6);
    chk("sim_recv", recv_count_o, 3);
    for (int i = 0; i < 40 && !done_o; i++) step(outstanding_o != 4'd0);
    chk("drain_done", 32'(done_o), 1);
    chk("drain_error", 32'(error_o), 0);
    chk("drain_sent", sent_count_o, 10);
    chk("drain_recv", recv_count_o, 10);
    chk("drain_q_empty", 32'(exp_q.size()), 0);

    // Watchdog timeout after one unanswered send
    do_reset();
    do_start(1);
    step(1'b0);
    n = 0;
    while (!error_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 16);
    tr_pkt_v_i = 1'b1;
    lce_tr_resp_v_i = 1'b1;
    #1;
    chk("timeout_done", 32'(done_o), 0);
    chk("timeout_pkt_v", 32'(lce_tr_pkt_v_o), 0);
    chk("timeout_yumi", 32'(tr_pkt_yumi_o), 0);
    chk("timeout_ready", 32'(lce_tr_resp_ready_o), 0);
    tr_pkt_v_i = 1'b0;
    lce_tr_resp_v_i = 1'b0;

    // Spurious response with nothing outstanding
    do_reset();
    do_start(0);
    step(1'b1);
    chk("spur_error", 32'(error_o), 1);
    chk("spur_recv", recv_count_o, 0);
    chk("spur_out", 32'(outstanding_o), 0);
    chk("spur_done", 32'(done_o), 0);

    // Asynchronous reset during drain, then a clean replay
    do_reset();
    do_start(2);
    step(1'b0);
    step(1'b0);
    chk("mid_out", 32'(outstanding_o), 2);
    chk("mid_ready", 32'(lce_tr_resp_ready_o), 1);
    #3;
    reset_i = 1'b1;
    #1;
    chk("async_out", 32'(outstanding_o), 0);
    chk("async_sent", sent_count_o, 0);
    chk("async_ready", 32'(lce_tr_resp_ready_o), 0);
    @(negedge clk);
    reset_i = 1'b0;
    exp_q.delete();
    pkt_left = 0;
    tr_pkt_v_i = 1'b0;
    step(1'b1);
    chk("post_rst_recv", recv_count_o, 0);
    chk("post_rst_error", 32'(error_o), 0);
    do_start(1);
    step(1'b0);
    step(1'b1);
    chk("replay_done", 32'(done_o), 1);
    chk("replay_sent", sent_count_o, 1);
    chk("replay_recv", recv_count_o, 1);
`ifdef BP_ME_NONSYNTH_TR_SEQ_PERF_EN
    chk("replay_total_cycles", total_cycles_o, 2);
`else
    chk("replay_total_cycles", total_cycles_o, 0);
`endif
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
